hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter MISS_TIMEOUT, default 255: miss-cycle count at which the timeout flag sets (1..255).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ID_RS, ID_RT  in  2 each  decode-stage source registers.
- ID_Use_RS, ID_Use_RT  in  1 each  decode instruction reads RS / RT.
- EX_Mem_Read  in  1  EX instruction is a load.
- EX_RD  in  2  EX destination register.
- Branch_Taken  in  1  EX resolves a taken branch or jump (incl. JRL).
- I_Cache_Req, I_Cache_Ready  in  1 each  fetch request pending / serviced.
- D_Cache_Req, D_Cache_Ready  in  1 each  data access pending / serviced.
- PC_Write, IF_ID_Write  out  1 each  enables for PC and IF/ID.
- ID_EX_Bubble, IF_ID_Flush  out  1 each  insert NOP into ID/EX / clear IF/ID.
- Pipe_Freeze  out  1  hold ID/EX and EX/MEM; bubble MEM/WB.
- State  out  2  FSM state: 00 RUN, 01 IMISS, 10 DMISS.
- Miss_Timeout  out  1  sticky error flag.

Function
REQ-003 SHALL compute dmiss = D_Cache_Req && !D_Cache_Ready and imiss = I_Cache_Req && !I_Cache_Ready, combinationally.
REQ-004 SHALL compute load_use = EX_Mem_Read && ((ID_Use_RS && EX_RD==ID_RS) || (ID_Use_RT && EX_RD==ID_RT)).
REQ-005 SHALL use priority dmiss > Branch_Taken > imiss > load_use, all outputs combinational on the same cycle.
REQ-006 On dmiss: Pipe_Freeze=1, PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=0, IF_ID_Flush=0; Branch_Taken ignored because EX is frozen and holds it.
REQ-007 On Branch_Taken without dmiss: IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1, IF_ID_Write=1, even if imiss or load_use.
REQ-008 On imiss only: PC_Write=0, IF_ID_Write=1, IF_ID_Flush=1; later stages advance.
REQ-009 On load_use only: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, for exactly one cycle per hazard.
REQ-010 With no condition active: PC_Write=1, IF_ID_Write=1, all other control outputs 0.
REQ-011 FSM transitions, evaluated at each clk edge:
- RUN->DMISS on dmiss; RUN->IMISS on imiss && !dmiss.
- IMISS->DMISS on dmiss; IMISS->RUN on !imiss.
- DMISS->IMISS on !dmiss && imiss; DMISS->RUN on !dmiss && !imiss.
REQ-012 The ready cycle releases the stall on that same cycle; state updates at the following edge.
REQ-013 SHALL keep an 8-bit miss counter: clears when the state changes; otherwise increments each cycle in IMISS/DMISS and saturates at 255.
REQ-014 SHALL set Miss_Timeout when the miss counter equals MISS_TIMEOUT; it stays set until reset.
REQ-015 Ready asserted with no request SHALL be ignored; two-bit register compare covers all four registers, register 0 included.

Reset
REQ-016 reset SHALL immediately, regardless of clk, force State=RUN, miss counter=0, Miss_Timeout=0, Stall_Cycles=0.
REQ-017 Reset asserted mid-miss SHALL abandon the miss; after release, outputs follow REQ-005..010 from inputs alone.

Configuration
REQ-018 Macro HAZARD_STALL_COUNT_EN:
- Defined: add output Stall_Cycles, 16-bit, incrementing each cycle PC_Write==0, wrapping 0xFFFF->0x0000.
- Undefined: the port and counter are absent; all other behaviour is identical.

Verification
REQ-019 EX_Mem_Read=1, EX_RD=2, ID_RS=2, ID_Use_RS=1 -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; next cycle, with EX_Mem_Read=0, outputs normal.
REQ-020 D_Cache_Req=1, Ready low for 5 cycles -> Pipe_Freeze=1 for 5 cycles, State=10 from cycle 2; on the ready cycle Pipe_Freeze=0, and State=00 one cycle later.
REQ-021 dmiss and Branch_Taken=1 together, then Ready -> no flush during the freeze; IF_ID_Flush=1 and ID_EX_Bubble=1 on the release cycle.
REQ-022 imiss during DMISS, D ready first -> State goes 10->01->00, and PC_Write stays 0 until I_Cache_Ready.
REQ-023 MISS_TIMEOUT=4 with D_Cache_Ready held low -> Miss_Timeout=1 after the 4th DMISS cycle; it stays 1 after ready, and clears only on reset.
REQ-024 reset pulsed mid-DMISS between clk edges -> State=00 immediately, and the miss counter equals 0.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: combinational stall/flush priority plus a cache-miss FSM
// with a saturating miss counter and sticky timeout. HAZARD_STALL_COUNT_EN adds Stall_Cycles.
module hazard_control_unit #(
  parameter int unsigned MISS_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ID_RS,
  input  logic [1:0] ID_RT,
  input  logic       ID_Use_RS,
  input  logic       ID_Use_RT,
  input  logic       EX_Mem_Read,
  input  logic [1:0] EX_RD,
  input  logic       Branch_Taken,
  input  logic       I_Cache_Req,
  input  logic       I_Cache_Ready,
  input  logic       D_Cache_Req,
  input  logic       D_Cache_Ready,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       ID_EX_Bubble,
  output logic       IF_ID_Flush,
  output logic       Pipe_Freeze,
  output logic [1:0] State,
  output logic       Miss_Timeout
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [15:0] Stall_Cycles
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    IMISS = 2'b01,
    DMISS = 2'b10
  } state_e;

  localparam logic [7:0] TimeoutVal = MISS_TIMEOUT[7:0];

  state_e     state_q, state_d;
  logic [7:0] missCnt_q, missCnt_d;
  logic       timeout_q, timeout_d;
  logic       dmiss, imiss, loadUse;

  assign dmiss   = D_Cache_Req && !D_Cache_Ready;
  assign imiss   = I_Cache_Req && !I_Cache_Ready;
  assign loadUse = EX_Mem_Read && ((ID_Use_RS && (EX_RD == ID_RS)) ||
                                   (ID_Use_RT && (EX_RD == ID_RT)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      missCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      missCnt_q <= missCnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (dmiss)      state_d = DMISS;
        else if (imiss) state_d = IMISS;
      end
      IMISS: begin
        if (dmiss)       state_d = DMISS;
        else if (!imiss) state_d = RUN;
      end
      DMISS: begin
        if (!dmiss) state_d = imiss ? IMISS : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Counter restarts on any state change so it measures time spent in the current miss.
  always_comb begin
    missCnt_d = missCnt_q;
    if (state_d != state_q)
      missCnt_d = '0;
    else if ((state_q != RUN) && (missCnt_q != 8'hFF))
      missCnt_d = missCnt_q + 8'd1;
  end

  assign timeout_d = timeout_q | (missCnt_d == TimeoutVal);

  // Outputs depend only on live inputs, so a ready cycle releases the stall immediately.
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    Pipe_Freeze  = 1'b0;
    if (dmiss) begin
      Pipe_Freeze = 1'b1;
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
    end else if (Branch_Taken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (imiss) begin
      PC_Write    = 1'b0;
      IF_ID_Flush = 1'b1;
    end else if (loadUse) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end
  end

  assign State        = state_q;
  assign Miss_Timeout = timeout_q;

`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] stallCnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stallCnt_q <= '0;
    else if (!PC_Write)
      stallCnt_q <= stallCnt_q + 16'd1;
  end

  assign Stall_Cycles = stallCnt_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: vector table, directed miss sequences
// and randomized cycles against a rule-level reference model.
module tb_hazard_control_unit;

  localparam int TO = 4;

  typedef struct packed {
    logic [1:0] idRs;
    logic [1:0] idRt;
    logic       useRs;
    logic       useRt;
    logic       exMemRead;
    logic [1:0] exRd;
    logic       branch;
    logic       iReq;
    logic       iRdy;
    logic       dReq;
    logic       dRdy;
  } stim_t;

  typedef struct packed {
    logic pcw;
    logic ifidw;
    logic bubble;
    logic flush;
    logic freeze;
  } ctrl_t;

  typedef struct {
    string name;
    stim_t s;
    ctrl_t e;
  } vec_t;

  logic       clk, reset;
  logic [1:0] ID_RS, ID_RT, EX_RD;
  logic       ID_Use_RS, ID_Use_RT, EX_Mem_Read, Branch_Taken;
  logic       I_Cache_Req, I_Cache_Ready, D_Cache_Req, D_Cache_Ready;
  logic       PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Pipe_Freeze;
  logic [1:0] State;
  logic       Miss_Timeout;
`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] Stall_Cycles;
`endif

  int compared, failed;
  int expState, expCnt, expStall;
  bit expTimeout;

  hazard_control_unit #(.MISS_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ID_RS(ID_RS), .ID_RT(ID_RT),
    .ID_Use_RS(ID_Use_RS), .ID_Use_RT(ID_Use_RT),
    .EX_Mem_Read(EX_Mem_Read), .EX_RD(EX_RD),
    .Branch_Taken(Branch_Taken),
    .I_Cache_Req(I_Cache_Req), .I_Cache_Ready(I_Cache_Ready),
    .D_Cache_Req(D_Cache_Req), .D_Cache_Ready(D_Cache_Ready),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .ID_EX_Bubble(ID_EX_Bubble), .IF_ID_Flush(IF_ID_Flush),
    .Pipe_Freeze(Pipe_Freeze), .State(State),
    .Miss_Timeout(Miss_Timeout)
`ifdef HAZARD_STALL_COUNT_EN
    , .Stall_Cycles(Stall_Cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mkS(input int rs, input int rt, input int urs, input int urt,
                                input int mr, input int rd, input int br, input int iq,
                                input int iy, input int dq, input int dy);
    stim_t s;
    s.idRs = 2'(rs); s.idRt = 2'(rt); s.useRs = 1'(urs); s.useRt = 1'(urt);
    s.exMemRead = 1'(mr); s.exRd = 2'(rd); s.branch = 1'(br);
    s.iReq = 1'(iq); s.iRdy = 1'(iy); s.dReq = 1'(dq); s.dRdy = 1'(dy);
    return s;
  endfunction

  function automatic vec_t mkVec(input string n, input stim_t s, input logic [4:0] e);
    vec_t v;
    v.name = n; v.s = s; v.e = ctrl_t'(e);
    return v;
  endfunction

  // Reference priority rules: data miss, then taken branch, then fetch miss, then load-use.
  function automatic ctrl_t refCtrl(input stim_t s);
    ctrl_t r;
    bit dm, im, lu;
    dm = s.dReq && !s.dRdy;
    im = s.iReq && !s.iRdy;
    lu = s.exMemRead && ((s.useRs && s.exRd == s.idRs) || (s.useRt && s.exRd == s.idRt));
    r = ctrl_t'(5'b11000);
    if (dm)      r = ctrl_t'(5'b00001);
    else if (s.branch) r = ctrl_t'(5'b11110);
    else if (im) r = ctrl_t'(5'b01010);
    else if (lu) r = ctrl_t'(5'b00100);
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    expState = 0; expCnt = 0; expTimeout = 0; expStall = 0;
  endtask

  task automatic modelEdge(input stim_t s);
    ctrl_t c;
    int ns;
    c  = refCtrl(s);
    ns = (s.dReq && !s.dRdy) ? 2 : ((s.iReq && !s.iRdy) ? 1 : 0);
    if (ns != expState) expCnt = 0;
    else if (expState != 0 && expCnt < 255) expCnt++;
    if (expCnt == TO) expTimeout = 1;
    expState = ns;
    if (!c.pcw) expStall = (expStall + 1) % 65536;
  endtask

  task automatic applyStimulus(input stim_t s);
    ID_RS = s.idRs; ID_RT = s.idRt; ID_Use_RS = s.useRs; ID_Use_RT = s.useRt;
    EX_Mem_Read = s.exMemRead; EX_RD = s.exRd; Branch_Taken = s.branch;
    I_Cache_Req = s.iReq; I_Cache_Ready = s.iRdy;
    D_Cache_Req = s.dReq; D_Cache_Ready = s.dRdy;
  endtask

  task automatic checkOutput(input stim_t s, input string tag);
    ctrl_t e;
    e = refCtrl(s);
    checkVal({tag, ".PC_Write"}, PC_Write, e.pcw);
    checkVal({tag, ".IF_ID_Write"}, IF_ID_Write, e.ifidw);
    checkVal({tag, ".ID_EX_Bubble"}, ID_EX_Bubble, e.bubble);
    checkVal({tag, ".IF_ID_Flush"}, IF_ID_Flush, e.flush);
    checkVal({tag, ".Pipe_Freeze"}, Pipe_Freeze, e.freeze);
    checkVal({tag, ".State"}, State, 16'(expState));
    checkVal({tag, ".Miss_Timeout"}, Miss_Timeout, 16'(expTimeout));
`ifdef HAZARD_STALL_COUNT_EN
    checkVal({tag, ".Stall_Cycles"}, Stall_Cycles, 16'(expStall));
`endif
  endtask

  // Called one time unit after a rising edge; ends at the same phase of the next cycle.
  task automatic runCycle(input stim_t s, input string tag);
    applyStimulus(s);
    @(negedge clk);
    checkOutput(s, tag);
    modelEdge(s);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous pulse placed between clock edges.
  task automatic pulseReset(input string tag);
    #1 reset = 1'b1;
    #1;
    checkVal({tag, ".rst_State"}, State, 16'd0);
    checkVal({tag, ".rst_missCnt"}, dut.missCnt_q, 16'd0);
    checkVal({tag, ".rst_Timeout"}, Miss_Timeout, 16'd0);
    #1 reset = 1'b0;
    modelReset();
  endtask

  vec_t tab[18];

  initial begin
    stim_t s, dm, im, dmIm, idle;
    logic [14:0] r;
    compared = 0; failed = 0;
    idle = mkS(0,0,0,0,0,0,0,0,0,0,0);
    dm   = mkS(0,0,0,0,0,0,0,0,0,1,0);
    im   = mkS(0,0,0,0,0,0,0,1,0,0,0);
    dmIm = mkS(0,0,0,0,0,0,0,1,0,1,0);

    tab[0]  = mkVec("idle",          idle,                         5'b11000);
    tab[1]  = mkVec("luRs",          mkS(2,0,1,0,1,2,0,0,0,0,0),   5'b00100);
    tab[2]  = mkVec("luRtReg0",      mkS(1,0,0,1,1,0,0,0,0,0,0),   5'b00100);
    tab[3]  = mkVec("matchNoUse",    mkS(1,0,0,0,1,1,0,0,0,0,0),   5'b11000);
    tab[4]  = mkVec("noLoad",        mkS(2,2,1,1,0,2,0,0,0,0,0),   5'b11000);
    tab[5]  = mkVec("luRtReg3",      mkS(0,3,0,1,1,3,0,0,0,0,0),   5'b00100);
    tab[6]  = mkVec("rtUnusedMatch", mkS(1,3,1,0,1,3,0,0,0,0,0),   5'b11000);
    tab[7]  = mkVec("branch",        mkS(0,0,0,0,0,0,1,0,0,0,0),   5'b11110);
    tab[8]  = mkVec("branchLu",      mkS(2,0,1,0,1,2,1,0,0,0,0),   5'b11110);
    tab[9]  = mkVec("imiss",         im,                           5'b01010);
    tab[10] = mkVec("iServed",       mkS(0,0,0,0,0,0,0,1,1,0,0),   5'b11000);
    tab[11] = mkVec("iRdyNoReq",     mkS(0,0,0,0,0,0,0,0,1,0,0),   5'b11000);
    tab[12] = mkVec("dRdyNoReq",     mkS(0,0,0,0,0,0,0,0,0,0,1),   5'b11000);
    tab[13] = mkVec("allHazards",    mkS(2,0,1,0,1,2,1,1,0,1,0),   5'b00001);
    tab[14] = mkVec("imissLu",       mkS(2,0,1,0,1,2,0,1,0,0,0),   5'b01010);
    tab[15] = mkVec("branchImiss",   mkS(0,0,0,0,0,0,1,1,0,0,0),   5'b11110);
    tab[16] = mkVec("dServedBranch", mkS(0,0,0,0,0,0,1,0,0,1,1),   5'b11110);
    tab[17] = mkVec("dmiss",         dm,                           5'b00001);

    reset = 1'b1;
    applyStimulus(dm);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkVal("init.State", State, 16'd0);
    checkVal("init.Timeout", Miss_Timeout, 16'd0);
    checkVal("init.missCnt", dut.missCnt_q, 16'd0);
`ifdef HAZARD_STALL_COUNT_EN
    checkVal("init.Stall", Stall_Cycles, 16'd0);
`endif
    applyStimulus(idle);
    reset = 1'b0;

    foreach (tab[i]) begin
      applyStimulus(tab[i].s);
      @(negedge clk);
      checkVal({tab[i].name, ".ctrl"}, 16'({PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Pipe_Freeze}),
               16'(tab[i].e));
      checkOutput(tab[i].s, tab[i].name);
      modelEdge(tab[i].s);
      @(posedge clk);
      #1;
    end
    runCycle(idle, "tabDrain");
    pulseReset("afterTab");

    // Load-use stalls one cycle, then normal flow once the load has moved on.
    runCycle(mkS(2,0,1,0,1,2,0,0,0,0,0), "lu1");
    runCycle(mkS(2,0,1,0,0,2,0,0,0,0,0), "lu2");

    pulseReset("preD");
    for (int c = 1; c <= 5; c++) begin
      runCycle(dm, "dmiss");
      checkVal("dmiss.StateAfter", State, 16'd2);
    end
    runCycle(mkS(0,0,0,0,0,0,0,1,1,1,1), "dReady");
    checkVal("dReady.StateAfter", State, 16'd0);

    pulseReset("preBr");
    for (int c = 0; c < 3; c++) runCycle(mkS(0,0,0,0,0,0,1,0,0,1,0), "brFrozen");
    runCycle(mkS(0,0,0,0,0,0,1,0,0,1,1), "brRelease");
    runCycle(idle, "brAfter");

    pulseReset("preDI");
    runCycle(dmIm, "di1");
    checkVal("di1.StateAfter", State, 16'd2);
    runCycle(dmIm, "di2");
    runCycle(mkS(0,0,0,0,0,0,0,1,0,1,1), "di3");
    checkVal("di3.StateAfter", State, 16'd1);
    runCycle(im, "di4");
    checkVal("di4.StateAfter", State, 16'd1);
    runCycle(mkS(0,0,0,0,0,0,0,1,1,0,0), "di5");
    checkVal("di5.StateAfter", State, 16'd0);

    // Timeout at 4 counted DMISS cycles, sticky across release until reset.
    pulseReset("preTo");
    for (int c = 1; c <= 5; c++) begin
      runCycle(dm, "to");
      checkVal($sformatf("to%0d.Timeout", c), Miss_Timeout, (c == 5) ? 16'd1 : 16'd0);
    end
    runCycle(mkS(0,0,0,0,0,0,0,0,0,1,1), "toReady");
    runCycle(idle, "toIdle");
    checkVal("toIdle.Timeout", Miss_Timeout, 16'd1);
    pulseReset("toClear");
    runCycle(idle, "toCleared");

    for (int c = 0; c < 3; c++) runCycle(dm, "midD");
    pulseReset("midD");
    runCycle(idle, "postRst");

    for (int n = 0; n < 2000; n++) begin
      r = 15'($urandom);
      s = stim_t'(r);
      s.iRdy = ($urandom_range(0, 2) != 0);
      s.dRdy = ($urandom_range(0, 1) != 0);
      runCycle(s, "rand");
      if ($urandom_range(0, 149) == 0) pulseReset("randRst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
